// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single combinational ALU.
// One operation is in flight at a time. The sequence is IDLE (accept),
// EXEC (ALU evaluates the latched operands) and RESP (hold the response
// until the owner takes it).
// Optional feature: define ALU_ARB_RR_EN to select round-robin arbitration
// on contention. Without it, requester 0 always wins contention.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    // requester 0
    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [XLEN-1:0] req_a_0,
    input  logic [XLEN-1:0] req_b_0,
    input  logic [2:0]      req_ctrl_0,
    output logic            rsp_valid_0,
    input  logic            rsp_ready_0,
    output logic [XLEN-1:0] rsp_result_0,
    output logic [4:0]      rsp_flags_0,

    // requester 1
    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [XLEN-1:0] req_a_1,
    input  logic [XLEN-1:0] req_b_1,
    input  logic [2:0]      req_ctrl_1,
    output logic            rsp_valid_1,
    input  logic            rsp_ready_1,
    output logic [XLEN-1:0] rsp_result_1,
    output logic [4:0]      rsp_flags_1,

    // shared ALU; alu_result/alu_flags are combinational from alu_a/b/ctrl
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      alu_flags
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            grant;        // winner this cycle (meaningful in IDLE)
    logic            grant_q;      // owner of the in-flight operation
    logic            accept;
    logic            rsp_ready_g;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [2:0]      op_ctrl;
    logic [XLEN-1:0] rsp_result_q;
    logic [4:0]      rsp_flags_q;

`ifdef ALU_ARB_RR_EN
    logic            last_grant;   // requester granted on the previous accept
`endif

    // Pick the winner among the currently valid requesters.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant = 1'b0;
        if (req_valid_0 && req_valid_1) begin
`ifdef ALU_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req_valid_1) begin
            grant = 1'b1;
        end
    end

    // Reset is folded in so that ready drops as soon as rst_n falls.
    assign accept      = rst_n && (state == IDLE) && (req_valid_0 || req_valid_1);
    assign req_ready_0 = accept && !grant;
    assign req_ready_1 = accept && grant;
    assign rsp_ready_g = grant_q ? rsp_ready_1 : rsp_ready_0;

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready_g) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's operands and identity on accept. The ALU ports
    // keep showing these values until the next accept.
    // NOTE: these registers drive output ports directly, so they are reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= 3'b000;
            grant_q <= 1'b0;
        end else if (accept) begin
            op_a    <= grant ? req_a_1    : req_a_0;
            op_b    <= grant ? req_b_1    : req_b_0;
            op_ctrl <= grant ? req_ctrl_1 : req_ctrl_0;
            grant_q <= grant;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Remember the last accepted requester for round-robin fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`endif

    // Capture the ALU output at the end of EXEC into the response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= 5'b00000;
        end else if (state == EXEC) begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= alu_flags;
        end
    end

    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_ctrl = op_ctrl;

    // Only the owner sees valid. Both ports show the shared response register.
    assign rsp_valid_0  = (state == RESP) && !grant_q;
    assign rsp_valid_1  = (state == RESP) &&  grant_q;
    assign rsp_result_0 = rsp_result_q;
    assign rsp_result_1 = rsp_result_q;
    assign rsp_flags_0  = rsp_flags_q;
    assign rsp_flags_1  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases followed by a randomized
// run scored against a transaction-level reference model. The shared ALU is
// modelled here and connected to the DUT's ALU ports.
`timescale 1ns/1ps
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_ready_0, req_valid_1, req_ready_1;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [2:0]  req_ctrl_0, req_ctrl_1;
    logic        rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
    logic [31:0] rsp_result_0, rsp_result_1;
    logic [4:0]  rsp_flags_0, rsp_flags_1;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic [4:0]  alu_flags;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_ctrl_0(req_ctrl_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_result_0(rsp_result_0), .rsp_flags_0(rsp_flags_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_ctrl_1(req_ctrl_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_result_1(rsp_result_1), .rsp_flags_1(rsp_flags_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {result, branch, overflow, carry, negative, zero}.
    function automatic logic [36:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v, br;
        s = '0; r = '0; c = 1'b0; v = 1'b0; br = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001, 3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
                br = (op == 3'b110) && (a == b);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = a << b[4:0];
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {r, br, v, c, r[31], (r == 32'd0)};
    endfunction

    assign {alu_result, alu_flags} = alu_ref(alu_a, alu_b, alu_ctrl);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive point is 1 ns after the rising edge; samples are taken on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int g, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] c);
        if (g == 0) begin
            req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_ctrl_0 = c;
        end else begin
            req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_ctrl_1 = c;
        end
    endtask

    // Wait (bounded) for a grant; g = -1 on timeout.
    task automatic wait_ready(output int g, input int budget);
        g = -1;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (req_ready_0 || req_ready_1) begin
                g = req_ready_1 ? 1 : 0;
                return;
            end
            if (i != budget - 1) tick();
        end
        check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic reset_dut();
        tick();
        set_req(0, 0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated operation on requester g with constant expected response.
    task automatic do_op(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [31:0] exp_res,
                         input logic [4:0] exp_flags);
        int w;
        tick();
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        set_req(g, 1, a, b, c);
        wait_ready(w, 10);
        check("op_grant", 64'(w), 64'(g));
        tick();
        set_req(g, 0, a, b, c);
        sample();
        check("exec_no_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check("exec_alu_ops", {alu_a, alu_b}, {a, b});
        check("exec_alu_ctrl", alu_ctrl, c);
        tick();
        sample();
        check("rsp_valid_owner", {rsp_valid_1, rsp_valid_0}, (g == 1) ? 2'b10 : 2'b01);
        check("rsp_result_0", rsp_result_0, exp_res);
        check("rsp_result_1", rsp_result_1, exp_res);
        check("rsp_flags", {rsp_flags_1, rsp_flags_0}, {exp_flags, exp_flags});
        tick();
    endtask

    function automatic logic [31:0] rand_opnd();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom());
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] held;
        logic [1:0]  exp_r, exp_v;
        bit          acc0, acc1;
        bit          m_busy, m_own, m_last;
        int          m_acc;
        logic [36:0] m_exp;

        rst_n = 1'b0;
        set_req(0, 1, 32'h55, 32'h66, 3'b011);   // valid during reset must not be granted
        set_req(1, 0, '0, '0, '0);
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        check("reset_ready", {req_ready_1, req_ready_0}, 2'b00);
        check("reset_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check("reset_rsp", {rsp_result_0, rsp_flags_0}, '0);
        check("reset_alu", {alu_a, alu_b, alu_ctrl}, '0);
        set_req(0, 0, '0, '0, '0);
        tick();
        rst_n = 1'b1;

        // Single op and flag boundaries; op codes 100/110 must pass through.
        do_op(0, 32'd5, 32'd3, 3'b001, 32'd2, 5'b00100);
        do_op(1, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 5'b01010);
        do_op(0, 32'd9, 32'd9, 3'b110, 32'd0, 5'b10101);
        do_op(1, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b100, 32'hFF00_EDCB, 5'b00010);

        // Contention: both requesters valid continuously from reset.
        reset_dut();
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        set_req(0, 1, 32'd1, 32'd1, 3'b000);
        set_req(1, 1, 32'd2, 32'd2, 3'b000);
        for (int k = 0; k < 4; k++) begin
            int eg;
            eg = RR ? (k % 2) : 0;
            wait_ready(w, 10);
            check("contend_grant", 64'(w), 64'(eg));
            tick();
            tick();
            sample();
            check("contend_valid", {rsp_valid_1, rsp_valid_0}, (eg == 1) ? 2'b10 : 2'b01);
            check("contend_result", rsp_result_0, (eg == 1) ? 32'd4 : 32'd2);
            tick();
        end
        set_req(0, 0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0);

        // Backpressure: owner 0 holds off; requester 1 waits.
        tick();
        rsp_ready_0 = 1'b0;
        set_req(0, 1, 32'd10, 32'd20, 3'b000);
        wait_ready(w, 10);
        check("bp_grant", 64'(w), 64'd0);
        tick();
        set_req(0, 0, '0, '0, '0);
        set_req(1, 1, 32'd7, 32'd8, 3'b011);
        sample();
        check("bp_exec_ready1", req_ready_1, 1'b0);
        tick();
        sample();
        held = rsp_result_0;
        check("bp_result", held, 32'd30);
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            check("bp_hold_valid", {rsp_valid_1, rsp_valid_0}, 2'b01);
            check("bp_hold_data", {rsp_result_0, rsp_flags_0}, {32'd30, 5'b00000});
            check("bp_hold_ready1", req_ready_1, 1'b0);
        end
        tick();
        rsp_ready_0 = 1'b1;
        sample();
        check("bp_release_valid", rsp_valid_0, 1'b1);
        tick();
        sample();
        check("bp_idle_valid", rsp_valid_0, 1'b0);
        check("bp_idle_ready1", req_ready_1, 1'b1);
        tick();
        set_req(1, 0, '0, '0, '0);
        tick();
        sample();
        check("bp_req1_result", {rsp_valid_1, rsp_result_1}, {1'b1, 32'd15});
        tick();

        // Reset while in EXEC: everything clears at once, no response afterwards.
        tick();
        set_req(0, 1, 32'hFFFF_FFFF, 32'h1234, 3'b100);
        wait_ready(w, 10);
        tick();
        set_req(0, 0, '0, '0, '0);
        set_req(1, 1, 32'd3, 32'd4, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready", {req_ready_1, req_ready_0}, 2'b00);
        check("rst_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check("rst_rsp", {rsp_result_0, rsp_result_1, rsp_flags_0, rsp_flags_1}, '0);
        check("rst_alu", {alu_a, alu_b, alu_ctrl}, '0);
        set_req(1, 0, '0, '0, '0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("post_rst_no_rsp", {rsp_valid_1, rsp_valid_0}, 2'b00);
            tick();
        end

        // Randomized traffic against the transaction-level model.
        reset_dut();
        acc0 = 0; acc1 = 0;
        m_busy = 0; m_own = 0; m_last = 1; m_acc = 0; m_exp = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc != 0) tick();
            if (acc0 || !req_valid_0) begin
                if ($urandom_range(0, 2) != 0) set_req(0, 1, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
                else set_req(0, 0, '0, '0, '0);
            end
            if (acc1 || !req_valid_1) begin
                if ($urandom_range(0, 2) != 0) set_req(1, 1, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
                else set_req(1, 0, '0, '0, '0);
            end
            acc0 = 0; acc1 = 0;
            rsp_ready_0 = ($urandom_range(0, 3) != 0);
            rsp_ready_1 = ($urandom_range(0, 3) != 0);
            sample();

            exp_v = 2'b00;
            if (m_busy && (cyc - m_acc) >= 2) exp_v[m_own] = 1'b1;
            exp_r = 2'b00;
            w = 0;
            if (!m_busy && (req_valid_0 || req_valid_1)) begin
                if (req_valid_0 && req_valid_1) w = RR ? int'(!m_last) : 0;
                else w = req_valid_1 ? 1 : 0;
                exp_r[w] = 1'b1;
            end
            check("rnd_ready", {req_ready_1, req_ready_0}, exp_r);
            check("rnd_rsp_valid", {rsp_valid_1, rsp_valid_0}, exp_v);
            if (exp_v != 2'b00) begin
                check("rnd_result", {rsp_result_0, rsp_flags_0}, m_exp);
                check("rnd_result_1", {rsp_result_1, rsp_flags_1}, m_exp);
                if ((m_own ? rsp_ready_1 : rsp_ready_0) == 1'b1) m_busy = 0;
            end
            if (exp_r != 2'b00) begin
                m_busy = 1;
                m_own  = w[0];
                m_last = w[0];
                m_acc  = cyc;
                m_exp  = (w == 1) ? alu_ref(req_a_1, req_b_1, req_ctrl_1)
                                  : alu_ref(req_a_0, req_b_0, req_ctrl_0);
                if (w == 1) acc1 = 1; else acc0 = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
